// File: rtl/dds_key_ctrl.sv
// dds_key_ctrl: DDS parameter controller driven by three debounced active-low keys.
// Latency: a key edge seen on the internal key register updates the outputs one clk later, so 2 clk after the raw key falls.
// Backpressure: none. Steps are applied as keys dictate, and cfg_valid pulses for one cycle whenever a value changes.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   key_mode_n/up_n/dn_n     debounced key levels, 0 = pressed
//   edit_sel                 edit target: 0 = FREQ, 1 = WAVE, 2 = AMP
//   freq_word                DDS frequency tuning word
//   wave_sel                 0 = sine, 1 = square, 2 = triangle, 3 = sawtooth
//   amp_sel                  amplitude attenuation code, 7 = full scale
//   cfg_valid                one-cycle pulse in the cycle the outputs change
module dds_key_ctrl #(
  parameter int unsigned     FW       = 32,
  parameter logic [FW-1:0]   F_STEP   = 32'd85_899,
  parameter logic [FW-1:0]   F_MIN    = 32'd85_899,
  parameter logic [FW-1:0]   F_MAX    = 32'd858_993_459,
  parameter logic [FW-1:0]   F_INIT   = 32'd85_899_346,
  parameter int unsigned     LONG_CYC = 25_000_000,
  parameter int unsigned     REP_CYC  = 5_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_mode_n,
  input  logic          key_up_n,
  input  logic          key_dn_n,
  output logic [1:0]    edit_sel,
  output logic [FW-1:0] freq_word,
  output logic [1:0]    wave_sel,
  output logic [2:0]    amp_sel,
  output logic          cfg_valid
);

  localparam int unsigned CNT_MAX = (LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
  // Below this threshold a down step would undershoot F_MIN. It is computed
  // one bit wider so that F_MIN + F_STEP cannot wrap.
  localparam logic [FW:0] F_DN_TH = {1'b0, F_MIN} + {1'b0, F_STEP};

  typedef enum logic [1:0] {IDLE, PRESS, REPEAT} state_t;

  // Key level registers and their previous values. Both reset to released,
  // so a key held through reset release is seen as a fresh press.
  logic mode_q, up_q, dn_q;
  logic mode_p, up_p, dn_p;
  logic mode_press, up_press, dn_press;

  state_t        state, state_nxt;
  logic          dir_up, dir_up_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          step, step_up, act_held;
  logic [1:0]    edit_nxt;

  logic [FW:0]   freq_sum;
  logic [FW-1:0] freq_nxt;
  logic [1:0]    wave_nxt;
  logic [2:0]    amp_nxt;
  logic          changed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b1;
      up_q   <= 1'b1;
      dn_q   <= 1'b1;
      mode_p <= 1'b1;
      up_p   <= 1'b1;
      dn_p   <= 1'b1;
    end else begin
      mode_q <= key_mode_n;
      up_q   <= key_up_n;
      dn_q   <= key_dn_n;
      mode_p <= mode_q;
      up_p   <= up_q;
      dn_p   <= dn_q;
    end
  end

  assign mode_press = mode_p & ~mode_q;
  assign up_press   = up_p & ~up_q;
  assign dn_press   = dn_p & ~dn_q;
  assign act_held   = dir_up ? ~up_q : ~dn_q;

  // Adjust FSM. The direction is latched on entry to PRESS, and the other
  // adjust key is ignored until the active key is released.
  always_comb begin
    state_nxt  = state;
    dir_up_nxt = dir_up;
    cnt_nxt    = cnt;
    step       = 1'b0;
    step_up    = dir_up;
    edit_nxt   = edit_sel;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (mode_press)
          edit_nxt = (edit_sel == 2'd2) ? 2'd0 : edit_sel + 2'd1;
        if (up_press && dn_q) begin
          step       = 1'b1;
          step_up    = 1'b1;
          dir_up_nxt = 1'b1;
          state_nxt  = PRESS;
        end else if (dn_press && up_q) begin
          step       = 1'b1;
          step_up    = 1'b0;
          dir_up_nxt = 1'b0;
          state_nxt  = PRESS;
        end
      end
      PRESS: begin
        if (!act_held) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          step      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = REPEAT;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (!act_held) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == REP_LAST) begin
          step    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Apply a step to the target selected by edit_sel.
  always_comb begin
    freq_nxt = freq_word;
    wave_nxt = wave_sel;
    amp_nxt  = amp_sel;
    freq_sum = {1'b0, freq_word} + {1'b0, F_STEP};
    if (step) begin
      case (edit_sel)
        2'd0: begin
          if (step_up)
            freq_nxt = (freq_sum > {1'b0, F_MAX}) ? F_MAX : freq_sum[FW-1:0];
          else
            freq_nxt = ({1'b0, freq_word} < F_DN_TH) ? F_MIN : freq_word - F_STEP;
        end
        2'd1: wave_nxt = step_up ? wave_sel + 2'd1 : wave_sel - 2'd1;
        2'd2: begin
          if (step_up)
            amp_nxt = (amp_sel == 3'd7) ? 3'd7 : amp_sel + 3'd1;
          else
            amp_nxt = (amp_sel == 3'd0) ? 3'd0 : amp_sel - 3'd1;
        end
        default: ;
      endcase
    end
    // A step that hits a saturation limit changes nothing and does not pulse.
    changed = (freq_nxt != freq_word) || (wave_nxt != wave_sel) || (amp_nxt != amp_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_up    <= 1'b1;
      cnt       <= '0;
      edit_sel  <= 2'd0;
      freq_word <= F_INIT;
      wave_sel  <= 2'd0;
      amp_sel   <= 3'd7;
      cfg_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      dir_up    <= dir_up_nxt;
      cnt       <= cnt_nxt;
      edit_sel  <= edit_nxt;
      freq_word <= freq_nxt;
      wave_sel  <= wave_nxt;
      amp_sel   <= amp_nxt;
      cfg_valid <= changed;
    end
  end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// tb_dds_key_ctrl: directed bench for dds_key_ctrl with small frequency limits and short hold times.
// Latency: each press is driven at a negedge, and outputs are sampled on the following negedges.
// Backpressure: none. Pulses on cfg_valid are logged with their cycle index relative to the first sampled edge.
module tb_dds_key_ctrl;

  localparam int unsigned   FW     = 32;
  localparam logic [31:0]   F_STEP = 32'd10;
  localparam logic [31:0]   F_MIN  = 32'd5;
  localparam logic [31:0]   F_MAX  = 32'd100;
  localparam logic [31:0]   F_INIT = 32'd49;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_mode_n, key_up_n, key_dn_n;
  logic [1:0]    edit_sel;
  logic [FW-1:0] freq_word;
  logic [1:0]    wave_sel;
  logic [2:0]    amp_sel;
  logic          cfg_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_at[$];

  dds_key_ctrl #(
    .FW(FW), .F_STEP(F_STEP), .F_MIN(F_MIN), .F_MAX(F_MAX), .F_INIT(F_INIT),
    .LONG_CYC(20), .REP_CYC(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(key_mode_n), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
    .edit_sel(edit_sel), .freq_word(freq_word), .wave_sel(wave_sel),
    .amp_sel(amp_sel), .cfg_valid(cfg_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // key: 0 = mode, 1 = up, 2 = down, 3 = up and down together
  task automatic set_keys(input int key, input logic lvl);
    case (key)
      0: key_mode_n = lvl;
      1: key_up_n   = lvl;
      2: key_dn_n   = lvl;
      default: begin
        key_up_n = lvl;
        key_dn_n = lvl;
      end
    endcase
  endtask

  // Key is held for 'hold' sampled edges. Index i is the negedge after the
  // i-th posedge following the key fall.
  task automatic press(input int key, input int hold);
    pulse_at.delete();
    @(negedge clk);
    set_keys(key, 1'b0);
    for (int i = 0; i < hold + 4; i++) begin
      @(negedge clk);
      if (i == hold - 1) set_keys(key, 1'b1);
      if (cfg_valid) pulse_at.push_back(i);
    end
  endtask

  function automatic int pulse_idx(input int n);
    return (pulse_at.size() > n) ? pulse_at[n] : -1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_freq"}, freq_word, F_INIT);
    check({tag, "_wave"}, wave_sel, 0);
    check({tag, "_amp"},  amp_sel, 7);
    check({tag, "_edit"}, edit_sel, 0);
    check({tag, "_cfg"},  cfg_valid, 0);
  endtask

  initial begin
    int rep_idx[5];
    int total;
    rep_idx = '{1, 21, 26, 31, 36};

    rst_n = 1'b0;
    key_mode_n = 1'b1;
    key_up_n   = 1'b1;
    key_dn_n   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Short up press: one step, pulse two clocks after the raw fall.
    press(1, 3);
    check("short_up_freq", freq_word, 59);
    check("short_up_npulse", pulse_at.size(), 1);
    check("short_up_pulse_cyc", pulse_idx(0), 1);

    // Long down hold: press step, +20 cycles, then every 5 cycles.
    press(2, 40);
    check("long_dn_npulse", pulse_at.size(), 5);
    for (int k = 0; k < 5; k++)
      check($sformatf("long_dn_pulse%0d_cyc", k), pulse_idx(k), rep_idx[k]);
    check("long_dn_freq", freq_word, 9);

    // Walk up to F_MAX-1, then saturate at F_MAX.
    total = 0;
    for (int k = 0; k < 9; k++) begin
      press(1, 3);
      total += pulse_at.size();
    end
    check("up_walk_freq", freq_word, 99);
    check("up_walk_npulse", total, 9);
    press(1, 3);
    check("fmax_freq", freq_word, 100);
    check("fmax_npulse", pulse_at.size(), 1);
    press(1, 3);
    check("fmax_sat_freq", freq_word, 100);
    check("fmax_sat_npulse", pulse_at.size(), 0);

    // Walk down to F_MIN+F_STEP-ish, clamp to F_MIN, then saturate.
    for (int k = 0; k < 9; k++) press(2, 3);
    check("dn_walk_freq", freq_word, 10);
    press(2, 3);
    check("fmin_freq", freq_word, 5);
    check("fmin_npulse", pulse_at.size(), 1);
    press(2, 3);
    check("fmin_sat_freq", freq_word, 5);
    check("fmin_sat_npulse", pulse_at.size(), 0);

    // Mode key cycles the edit target without pulsing cfg_valid.
    press(0, 3);
    check("mode1_edit", edit_sel, 1);
    check("mode1_npulse", pulse_at.size(), 0);
    press(0, 3);
    check("mode2_edit", edit_sel, 2);

    // Amplitude down to 0 and saturate.
    total = 0;
    for (int k = 0; k < 7; k++) begin
      press(2, 3);
      total += pulse_at.size();
    end
    check("amp_walk", amp_sel, 0);
    check("amp_walk_npulse", total, 7);
    press(2, 3);
    check("amp_sat", amp_sel, 0);
    check("amp_sat_npulse", pulse_at.size(), 0);
    press(1, 3);
    check("amp_up", amp_sel, 1);

    press(0, 3);
    check("mode_wrap_edit", edit_sel, 0);
    check("mode_wrap_freq", freq_word, 5);
    press(0, 3);
    check("mode_wave_edit", edit_sel, 1);

    // Waveform wraps in both directions.
    press(2, 3);
    check("wave_dn_wrap", wave_sel, 3);
    check("wave_dn_npulse", pulse_at.size(), 1);
    press(1, 3);
    check("wave_up_wrap", wave_sel, 0);

    // Up and down falling together do nothing.
    press(3, 3);
    check("both_wave", wave_sel, 0);
    check("both_npulse", pulse_at.size(), 0);

    // Down pressed while up is held in PRESS is ignored.
    pulse_at.delete();
    @(negedge clk);
    key_up_n = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 3) key_dn_n = 1'b0;
      if (i == 9) begin
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
      end
      if (cfg_valid) pulse_at.push_back(i);
    end
    check("up_hold_dn_wave", wave_sel, 1);
    check("up_hold_dn_npulse", pulse_at.size(), 1);

    // Reset asserted mid-REPEAT clears everything at once.
    @(negedge clk);
    key_up_n = 1'b0;
    repeat (25) @(negedge clk);
    check("repeat_wave", wave_sel, 3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    key_up_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_vals("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
